// File: rtl/eth_tx_frame_builder_if.sv
// Byte-wide AXI-Stream link used for the payload input and the frame output of
// eth_tx_frame_builder.
interface eth_tx_frame_builder_if #(
  parameter int DATA_WIDTH = 8
);
  // A byte moves on a rising edge where tvalid & trdy are both high; once
  // tvalid is raised the master keeps tdata/tlast stable until that edge.
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  trdy;

  modport master (output tdata, output tvalid, output tlast, input trdy);
  modport slave  (input tdata, input tvalid, input tlast, output trdy);
endinterface

// File: rtl/eth_tx_frame_builder.sv
// TX frame builder: emits dst/src/EtherType header followed by the payload stream.
// Optional 802.1Q tag insertion is enabled by defining ETH_TX_VLAN_TAG_EN.
module eth_tx_frame_builder #(
  parameter int DATA_WIDTH      = 8,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic [47:0]                i_dst_mac,
  input  logic [47:0]                i_src_mac,
  input  logic [15:0]                i_eth_type,
`ifdef ETH_TX_VLAN_TAG_EN
  input  logic [15:0]                i_vlan_tci,
`endif
  input  logic                       i_hdr_valid,
  output logic                       o_hdr_rdy,
  eth_tx_frame_builder_if.slave      s_axis,
  eth_tx_frame_builder_if.master     m_axis,
  output logic                       o_busy,
  output logic [FRAME_CNT_WIDTH-1:0] o_frame_cnt,
  output logic [1:0]                 o_dbg_state
);

`ifdef ETH_TX_VLAN_TAG_EN
  localparam int HDR_LEN = 18;
`else
  localparam int HDR_LEN = 14;
`endif
  localparam int HW = HDR_LEN * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  state_t        state;
  logic [HW-1:0] hdr_sr;
  logic [HW-1:0] hdr_word;
  logic [4:0]    idx;
  logic          load_en;

  always_comb begin
`ifdef ETH_TX_VLAN_TAG_EN
    hdr_word = {i_dst_mac, i_src_mac, 16'h8100, i_vlan_tci, i_eth_type};
`else
    hdr_word = {i_dst_mac, i_src_mac, i_eth_type};
`endif
  end

  assign load_en     = !m_axis.tvalid || m_axis.trdy;
  assign s_axis.trdy = (state == PAYLOAD) && load_en;
  assign o_hdr_rdy   = (state == IDLE);
  assign o_busy      = (state != IDLE);
  assign o_dbg_state = state;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= IDLE;
      hdr_sr        <= '0;
      idx           <= '0;
      m_axis.tdata  <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tlast  <= 1'b0;
      o_frame_cnt   <= '0;
    end else begin
      if (m_axis.tvalid && m_axis.trdy && m_axis.tlast)
        o_frame_cnt <= o_frame_cnt + FRAME_CNT_WIDTH'(1);

      case (state)
        IDLE: begin
          if (load_en) begin
            m_axis.tvalid <= 1'b0;
            m_axis.tlast  <= 1'b0;
          end
          if (i_hdr_valid) begin
            state <= HEADER;
            // Loading byte 0 straight from the inputs gives first-beat latency
            // of one cycle and zero-gap back-to-back frames.
            if (load_en) begin
              m_axis.tdata  <= hdr_word[HW-1 -: DATA_WIDTH];
              m_axis.tvalid <= 1'b1;
              m_axis.tlast  <= 1'b0;
              hdr_sr        <= hdr_word << DATA_WIDTH;
              idx           <= 5'd1;
            end else begin
              hdr_sr <= hdr_word;
              idx    <= 5'd0;
            end
          end
        end

        HEADER: begin
          if (load_en) begin
            m_axis.tdata  <= hdr_sr[HW-1 -: DATA_WIDTH];
            m_axis.tvalid <= 1'b1;
            m_axis.tlast  <= 1'b0;
            hdr_sr        <= hdr_sr << DATA_WIDTH;
            idx           <= idx + 5'd1;
            if (idx == 5'(HDR_LEN - 1))
              state <= PAYLOAD;
          end
        end

        PAYLOAD: begin
          if (load_en) begin
            if (s_axis.tvalid) begin
              m_axis.tdata  <= s_axis.tdata;
              m_axis.tvalid <= 1'b1;
              m_axis.tlast  <= s_axis.tlast;
              if (s_axis.tlast)
                state <= IDLE;
            end else begin
              m_axis.tvalid <= 1'b0;
              m_axis.tlast  <= 1'b0;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_frame_builder.sv
// Self-checking bench for eth_tx_frame_builder: table of frames, random traffic,
// back-to-back, mid-frame reset and frame counter wrap.
module tb_eth_tx_frame_builder;
  localparam int CW = 16;
`ifdef ETH_TX_VLAN_TAG_EN
  localparam int HDR_LEN = 18;
`else
  localparam int HDR_LEN = 14;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [47:0]   dst_mac, src_mac;
  logic [15:0]   eth_type;
`ifdef ETH_TX_VLAN_TAG_EN
  logic [15:0]   vlan_tci;
`endif
  logic          hdr_valid;
  wire           hdr_rdy;
  wire           busy;
  wire [CW-1:0]  frame_cnt;
  wire [1:0]     dbg_state;

  eth_tx_frame_builder_if #(.DATA_WIDTH(8)) s_axis ();
  eth_tx_frame_builder_if #(.DATA_WIDTH(8)) m_axis ();

  eth_tx_frame_builder #(.DATA_WIDTH(8), .FRAME_CNT_WIDTH(CW)) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_dst_mac   (dst_mac),
    .i_src_mac   (src_mac),
    .i_eth_type  (eth_type),
`ifdef ETH_TX_VLAN_TAG_EN
    .i_vlan_tci  (vlan_tci),
`endif
    .i_hdr_valid (hdr_valid),
    .o_hdr_rdy   (hdr_rdy),
    .s_axis      (s_axis),
    .m_axis      (m_axis),
    .o_busy      (busy),
    .o_frame_cnt (frame_cnt),
    .o_dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] typ;
    logic [15:0] tci;
  } hdr_t;

  typedef struct {
    hdr_t h;
    int   plen;
    int   mode;       // 0: trdy=1, 1: toggle 1,0,1,0, 2: random
    bit   gaps;       // random bubbles on the payload source
    int   exp_beats;
  } vec_t;

  // scoreboard / model state
  hdr_t        hdr_pend[$];
  logic [8:0]  pay_q[$];
  logic [8:0]  exp_q[$];
  logic [CW-1:0] exp_cnt = '0;
  int n_checks = 0, n_pass = 0;
  int frame_beats = 0, run_beats = 0, cyc = 0, first_cyc = -1, last_cyc = -1;
  int stall_err = 0, lat_err = 0, trdy_err = 0;
  int hdr_hold = 0, trdy_mode = 0;
  bit src_gaps = 0;
  bit prev_stall = 0, exp_lat_valid = 0;
  logic [7:0] prev_data, exp_lat_data;
  logic prev_last;
  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) $display("FAIL %s: got %0h, expected %0h", name, act, req);
    else n_pass++;
  endtask

  task automatic queue_frame(input hdr_t h, input int len, input bit rnd, input logic [7:0] base);
    logic [7:0] b;
    logic [8:0] e;
    hdr_pend.push_back(h);
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, 8'(h.dst >> (40 - 8 * i))});
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, 8'(h.src >> (40 - 8 * i))});
`ifdef ETH_TX_VLAN_TAG_EN
    exp_q.push_back(9'h081);
    exp_q.push_back(9'h000);
    exp_q.push_back({1'b0, h.tci[15:8]});
    exp_q.push_back({1'b0, h.tci[7:0]});
`endif
    exp_q.push_back({1'b0, h.typ[15:8]});
    exp_q.push_back({1'b0, h.typ[7:0]});
    for (int i = 0; i < len; i++) begin
      b = rnd ? 8'($urandom) : 8'(base + i);
      e = {(i == len - 1), b};
      pay_q.push_back(e);
      exp_q.push_back(e);
    end
  endtask

  // driver: called just after a rising edge
  task automatic drive();
    if (hdr_hold > 0) hdr_hold--;
    if (hdr_pend.size() > 0 && hdr_hold == 0) begin
      hdr_valid = 1'b1;
      dst_mac   = hdr_pend[0].dst;
      src_mac   = hdr_pend[0].src;
      eth_type  = hdr_pend[0].typ;
`ifdef ETH_TX_VLAN_TAG_EN
      vlan_tci  = hdr_pend[0].tci;
`endif
    end else begin
      hdr_valid = 1'b0;
      dst_mac   = 48'({$urandom(), $urandom()});
      src_mac   = 48'({$urandom(), $urandom()});
      eth_type  = 16'($urandom);
`ifdef ETH_TX_VLAN_TAG_EN
      vlan_tci  = 16'($urandom);
`endif
    end
    if (pay_q.size() > 0 && (!src_gaps || $urandom_range(0, 3) != 0)) begin
      s_axis.tvalid = 1'b1;
      s_axis.tdata  = pay_q[0][7:0];
      s_axis.tlast  = pay_q[0][8];
    end else begin
      s_axis.tvalid = 1'b0;
      s_axis.tdata  = 8'($urandom);
      s_axis.tlast  = 1'($urandom);
    end
    case (trdy_mode)
      0:       m_axis.trdy = 1'b1;
      1:       m_axis.trdy = ~m_axis.trdy;
      default: m_axis.trdy = 1'($urandom_range(0, 1));
    endcase
  endtask

  // one cycle: sample at the falling edge, then advance past the rising edge
  task automatic tick();
    logic h_acc, s_acc, ld;
    logic [8:0] e;
    @(negedge clk);
    cyc++;
    h_acc = hdr_valid && hdr_rdy;
    s_acc = s_axis.tvalid && s_axis.trdy;
    ld    = !m_axis.tvalid || m_axis.trdy;
    if (exp_lat_valid && !(m_axis.tvalid && m_axis.tdata == exp_lat_data)) lat_err++;
    exp_lat_valid = 1'b0;
    if (prev_stall && !(m_axis.tvalid && m_axis.tdata == prev_data && m_axis.tlast == prev_last))
      stall_err++;
    if (s_axis.trdy && (hdr_rdy || (m_axis.tvalid && frame_beats + 1 < HDR_LEN))) trdy_err++;
    prev_stall = m_axis.tvalid && !m_axis.trdy;
    prev_data  = m_axis.tdata;
    prev_last  = m_axis.tlast;
    if (m_axis.tvalid && m_axis.trdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {55'd0, m_axis.tlast, m_axis.tdata}, 64'h1ff);
      end else begin
        e = exp_q.pop_front();
        check("beat", {55'd0, m_axis.tlast, m_axis.tdata}, {55'd0, e});
        if (e[8]) begin
          exp_cnt++;
          frame_beats = 0;
        end else frame_beats++;
      end
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      run_beats++;
    end
    if (h_acc && ld) begin
      exp_lat_valid = 1'b1;
      exp_lat_data  = hdr_pend[0].dst[47:40];
    end
    if (s_acc) begin
      exp_lat_valid = 1'b1;
      exp_lat_data  = s_axis.tdata;
    end
    @(posedge clk);
    #1;
    if (h_acc) void'(hdr_pend.pop_front());
    if (s_acc) void'(pay_q.pop_front());
    drive();
  endtask

  task automatic run(input int mode, input bit gaps, input int stop_at);
    int n = 0;
    trdy_mode = mode;
    src_gaps  = gaps;
    run_beats = 0; first_cyc = -1; last_cyc = -1;
    stall_err = 0; lat_err = 0; trdy_err = 0;
    m_axis.trdy = 1'b0;
    drive();
    while ((exp_q.size() > 0 || hdr_pend.size() > 0) && n < 5000 &&
           !(stop_at > 0 && run_beats >= stop_at)) begin
      tick();
      n++;
    end
    if (n >= 5000) check("timeout", 64'd0, 64'd1);
  endtask

  task automatic end_checks(input bit gapless);
    if (gapless) check("gapless", 64'(last_cyc - first_cyc + 1), 64'(run_beats));
    check("frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
    check("stall_hold", 64'(stall_err), 64'd0);
    check("latency", 64'(lat_err), 64'd0);
    check("s_trdy_gate", 64'(trdy_err), 64'd0);
  endtask

  initial begin
    hdr_t h;
    hdr_valid = 1'b0; dst_mac = '0; src_mac = '0; eth_type = '0;
`ifdef ETH_TX_VLAN_TAG_EN
    vlan_tci = '0;
`endif
    s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tlast = 1'b0; m_axis.trdy = 1'b0;

    vecs[0] = '{h: '{48'hFFFF_FFFF_FFFF, 48'h000A_3501_0203, 16'h0800, 16'h6064},
                plen: 46, mode: 0, gaps: 0, exp_beats: HDR_LEN + 46};
    vecs[1] = '{h: '{48'hFFFF_FFFF_FFFF, 48'h000A_3501_0203, 16'h0800, 16'h6064},
                plen: 46, mode: 1, gaps: 0, exp_beats: HDR_LEN + 46};
    vecs[2] = '{h: '{48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}), 16'h86DD, 16'h6064},
                plen: 1, mode: 2, gaps: 1, exp_beats: HDR_LEN + 1};
    vecs[3] = '{h: '{48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}), 16'h88B5, 16'hE123},
                plen: 64, mode: 2, gaps: 1, exp_beats: HDR_LEN + 64};
    vecs[4] = '{h: '{48'h0102_0304_0506, 48'hA1A2_A3A4_A5A6, 16'h86DD, 16'h6064},
                plen: 3, mode: 0, gaps: 1, exp_beats: HDR_LEN + 3};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_hdr_rdy", 64'(hdr_rdy), 64'd1);
    check("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
    check("rst_tlast_tdata", {55'd0, m_axis.tlast, m_axis.tdata}, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_s_trdy", 64'(s_axis.trdy), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);

    // table: first entry has payload valid from reset release, header held back
    for (int i = 0; i < 5; i++) begin
      queue_frame(vecs[i].h, vecs[i].plen, (i >= 2), 8'h00);
      if (i == 0) hdr_hold = 4;
      rst_n = 1'b1;
      run(vecs[i].mode, vecs[i].gaps, 0);
      check("beats", 64'(run_beats), 64'(vecs[i].exp_beats));
      end_checks(vecs[i].mode == 0 && !vecs[i].gaps);
    end

    // random traffic, several queued frames
    for (int i = 0; i < 6; i++) begin
      h = '{48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}), 16'($urandom), 16'($urandom)};
      queue_frame(h, $urandom_range(1, 40), 1'b1, 8'h00);
    end
    run(2, 1'b1, 0);
    end_checks(1'b0);

    // back-to-back single-byte frames
    h = '{48'h1111_2222_3333, 48'h4444_5555_6666, 16'h0800, 16'h0001};
    queue_frame(h, 1, 1'b0, 8'hAA);
    queue_frame(h, 1, 1'b0, 8'hBB);
    run(0, 1'b0, 0);
    check("b2b_beats", 64'(run_beats), 64'(2 * (HDR_LEN + 1)));
    end_checks(1'b1);

    // reset while payload beat 20 is on the output
    queue_frame(vecs[0].h, 46, 1'b0, 8'h00);
    run(0, 1'b0, HDR_LEN + 19);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", 64'(m_axis.tvalid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_hdr_rdy", 64'(hdr_rdy), 64'd1);
    check("mid_rst_cnt", 64'(frame_cnt), 64'd0);
    exp_q.delete(); pay_q.delete(); hdr_pend.delete();
    exp_cnt = '0; frame_beats = 0; prev_stall = 1'b0; exp_lat_valid = 1'b0;
    hdr_valid = 1'b0; s_axis.tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    queue_frame(vecs[4].h, 10, 1'b1, 8'h00);
    run(0, 1'b0, 0);
    check("post_rst_beats", 64'(run_beats), 64'(HDR_LEN + 10));
    end_checks(1'b1);

    // frame counter wrap
    force dut.o_frame_cnt = 16'hFFFF;
    #1;
    release dut.o_frame_cnt;
    exp_cnt = 16'hFFFF;
    check("cnt_preload", 64'(frame_cnt), 64'hFFFF);
    queue_frame(vecs[2].h, 5, 1'b1, 8'h00);
    run(2, 1'b0, 0);
    check("cnt_wrap", 64'(frame_cnt), 64'h0);
    end_checks(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
